// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard MMIO block.
// Receiver state encoding, register offsets and STATUS bit positions.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int STAT_NE_BIT   = 0;
  localparam int STAT_OVF_BIT  = 1;
  localparam int STAT_PERR_BIT = 2;
  localparam int STAT_CNT_LSB  = 3;
  localparam int STAT_CNT_MSB  = 7;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizer, falling-edge detect, 11-bit frame FSM, inactivity timeout.
// Latency: rx_vld pulses one cycle after the stop bit is sampled.
// Backpressure: none; the keyboard cannot be stalled. Parity check under KBD_PARITY_CHECK_EN.
module ps2_rx_frame
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  output logic       parity_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fall, bit_in, timeout;
  rx_state_e     state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt, dat_nxt;
  logic          par_bit, par_bit_nxt;
  logic [TW-1:0] idle_cnt, idle_cnt_nxt;
  logic          vld_nxt, perr_nxt;

  assign fall    = clk_prev & ~clk_sync[1];
  assign bit_in  = dat_sync[1];
  assign timeout = (state != ST_IDLE) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_prev   <= 1'b1;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      idle_cnt   <= '0;
      rx_dat     <= '0;
      rx_vld     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      clk_prev   <= clk_sync[1];
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      par_bit    <= par_bit_nxt;
      idle_cnt   <= idle_cnt_nxt;
      rx_dat     <= dat_nxt;
      rx_vld     <= vld_nxt;
      parity_err <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    par_bit_nxt  = par_bit;
    dat_nxt      = rx_dat;
    vld_nxt      = 1'b0;
    perr_nxt     = 1'b0;
    idle_cnt_nxt = (state == ST_IDLE || fall) ? '0 : idle_cnt + 1'b1;
    if (timeout) begin
      state_nxt    = ST_IDLE;
      idle_cnt_nxt = '0;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!bit_in) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shift_nxt   = {bit_in, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          par_bit_nxt = bit_in;
          state_nxt   = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (bit_in) begin
`ifdef KBD_PARITY_CHECK_EN
            if (odd_parity_ok(shift, par_bit)) begin
              vld_nxt = 1'b1;
              dat_nxt = shift;
            end else begin
              perr_nxt = 1'b1;
            end
`else
            vld_nxt = 1'b1;
            dat_nxt = shift;
`endif
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/kbd_ps2_mmio.sv
// PS/2 keyboard receiver with byte FIFO behind a DATA/STATUS load-only MMIO window.
// Latency: byte visible and kbd_irq high two cycles after the stop bit is sampled; reads are combinational.
// Backpressure: none; bytes arriving at a full FIFO are dropped and flagged (parity check under KBD_PARITY_CHECK_EN).
module kbd_ps2_mmio
  import kbd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_FF00,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        MemRead,
  input  logic [31:0] dataAddr,
  output logic [31:0] readData,
  output logic        kbd_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    rx_dat;
  logic          rx_vld, rx_perr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic          ovf, perr_sticky;
  logic          hit_data, hit_status, not_empty, full;
  logic          pop, do_write, ovf_evt;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_dat     (rx_dat),
    .rx_vld     (rx_vld),
    .parity_err (rx_perr)
  );

  assign hit_data   = MemRead && (dataAddr == BASE_ADDR + DATA_OFS);
  assign hit_status = MemRead && (dataAddr == BASE_ADDR + STATUS_OFS);
  assign not_empty  = (count != '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = hit_data && not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_write   = rx_vld && (!full || pop);
  assign ovf_evt    = rx_vld && full && !pop;
  assign count_nxt  = count + CW'(do_write) - CW'(pop);

  always_comb begin
    readData = '0;
    if (pop) begin
      readData[7:0] = mem[rptr];
    end else if (hit_status) begin
      readData[STAT_NE_BIT]                = not_empty;
      readData[STAT_OVF_BIT]               = ovf;
      readData[STAT_PERR_BIT]              = perr_sticky;
      readData[STAT_CNT_MSB:STAT_CNT_LSB]  = 5'(count);
    end
  end

  always_ff @(posedge clk_50m) begin
    if (do_write) mem[wptr] <= rx_dat;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      perr_sticky <= 1'b0;
      kbd_irq     <= 1'b0;
    end else begin
      if (do_write) wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
      count   <= count_nxt;
      kbd_irq <= (count_nxt != '0);
      // A fresh error event wins over the clear-on-read of STATUS.
      if (ovf_evt)         ovf <= 1'b1;
      else if (hit_status) ovf <= 1'b0;
      if (rx_perr)         perr_sticky <= 1'b1;
      else if (hit_status) perr_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kbd_ps2_mmio.sv
// Bench for kbd_ps2_mmio: vector table, directed corner sequences, randomized traffic vs a queue model.
module tb_kbd_ps2_mmio;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam int          H    = 5;
  localparam int          DEPTH = 8;

  logic        clk_50m = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        MemRead = 1'b0;
  logic [31:0] dataAddr = '0;
  logic [31:0] readData;
  logic        kbd_irq;

  int total = 0;
  int bad = 0;

  kbd_ps2_mmio dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .MemRead  (MemRead),
    .dataAddr (dataAddr),
    .readData (readData),
    .kbd_irq  (kbd_irq)
  );

  always #10 clk_50m = ~clk_50m;

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          send;
    logic [7:0]  dat;
    bit          good;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  // Reference model: received bytes in arrival order plus sticky flags.
  logic [7:0] m_q[$];
  bit m_ovf = 0;
  bit m_perr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit good);
    logic p;
    p = good ? ~(^d) : (^d);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50m); ps2_data = f[i];
      repeat (H) @(negedge clk_50m);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk_50m);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit good);
    send_bits(mk_frame(d, good), 11);
    repeat (8) @(negedge clk_50m);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_50m);
    MemRead = 1'b1; dataAddr = a;
    #1 d = readData;
    @(negedge clk_50m);
    MemRead = 1'b0; dataAddr = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic m_frame(input logic [7:0] d, input bit good);
`ifdef KBD_PARITY_CHECK_EN
    if (!good) begin
      m_perr = 1;
      return;
    end
`endif
    if (m_q.size() < DEPTH) m_q.push_back(d);
    else m_ovf = 1;
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] exp);
    exp = '0;
    if (a == BASE) begin
      if (m_q.size() != 0) exp = {24'h0, m_q.pop_front()};
    end else if (a == STAT) begin
      exp = (32'(m_q.size()) << 3) | (32'(m_perr) << 2) | (32'(m_ovf) << 1) | 32'(m_q.size() != 0);
      m_ovf = 0;
      m_perr = 0;
    end
  endtask

  initial begin
    logic [31:0] d, e;
    logic [31:0] a;
    bit seen;

    tbl[0]  = '{1, 8'h1C, 1, BASE, 32'h0000_001C};
    tbl[1]  = '{1, 8'hA5, 1, STAT, 32'h0000_0009};
    tbl[2]  = '{0, 8'h00, 1, BASE, 32'h0000_00A5};
    tbl[3]  = '{0, 8'h00, 1, BASE, 32'h0000_0000};
    tbl[4]  = '{0, 8'h00, 1, BASE + 32'd8, 32'h0000_0000};
    tbl[5]  = '{1, 8'h00, 1, BASE + 32'd1, 32'h0000_0000};
    tbl[6]  = '{0, 8'h00, 1, STAT, 32'h0000_0009};
    tbl[7]  = '{0, 8'h00, 1, BASE, 32'h0000_0000};
    tbl[8]  = '{1, 8'hFF, 1, BASE, 32'h0000_00FF};
`ifdef KBD_PARITY_CHECK_EN
    tbl[9]  = '{1, 8'h5A, 0, STAT, 32'h0000_0004};
    tbl[10] = '{0, 8'h00, 1, BASE, 32'h0000_0000};
`else
    tbl[9]  = '{1, 8'h5A, 0, STAT, 32'h0000_0009};
    tbl[10] = '{0, 8'h00, 1, BASE, 32'h0000_005A};
`endif
    tbl[11] = '{0, 8'h00, 1, STAT, 32'h0000_0000};

    // Reset state
    repeat (3) @(negedge clk_50m);
    chk("reset_irq", 32'(kbd_irq), 32'h0);
    rst_n = 1'b1;
    rd_chk("reset_status", STAT, 32'h0);
    rd_chk("reset_data", BASE, 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].send) send_frame(tbl[i].dat, tbl[i].good);
      rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // Single byte: irq latency, read, irq drop
    send_bits(mk_frame(8'h1C, 1), 10);
    @(negedge clk_50m); ps2_data = 1'b1;
    repeat (H) @(negedge clk_50m);
    ps2_clk = 1'b0;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk_50m);
      seen = kbd_irq;
    end
    chk("irq_rise", 32'(seen), 32'h1);
    @(negedge clk_50m); ps2_clk = 1'b1;
    rd_chk("irq_data", BASE, 32'h0000_001C);
    chk("irq_fall", 32'(kbd_irq), 32'h0);

    // Overflow: nine bytes into eight slots
    for (int b = 1; b <= 9; b++) send_frame(8'(b), 1);
    rd_chk("ovf_status", STAT, 32'h0000_0043);
    for (int b = 1; b <= 8; b++) rd_chk($sformatf("ovf_data%0d", b), BASE, 32'(b));
    rd_chk("ovf_cleared", STAT, 32'h0);

    // Timeout abandons a partial frame
    send_bits(mk_frame(8'hE7, 1), 5);
    repeat (60000) @(negedge clk_50m);
    send_frame(8'h29, 1);
    rd_chk("tmo_status", STAT, 32'h0000_0009);
    rd_chk("tmo_data", BASE, 32'h0000_0029);
    rd_chk("tmo_empty", BASE, 32'h0);

    // Full FIFO, DATA read lands on the push cycle
    for (int b = 0; b < 8; b++) send_frame(8'h10 + 8'(b), 1);
    send_bits(mk_frame(8'h18, 1), 10);
    @(negedge clk_50m); ps2_data = 1'b1;
    repeat (H) @(negedge clk_50m);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk_50m);
    rd_chk("simul_data", BASE, 32'h0000_0010);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk_50m);
    rd_chk("simul_status", STAT, 32'h0000_0041);
    for (int b = 1; b <= 8; b++) rd_chk($sformatf("simul_order%0d", b), BASE, 32'h10 + 32'(b));

    // Reset mid-frame
    send_frame(8'h77, 1);
    send_bits(mk_frame(8'hC3, 1), 5);
    @(negedge clk_50m); rst_n = 1'b0;
    repeat (2) @(negedge clk_50m);
    MemRead = 1'b1; dataAddr = STAT;
    #1 chk("rst_mid_status", readData, 32'h0);
    chk("rst_mid_irq", 32'(kbd_irq), 32'h0);
    @(negedge clk_50m); MemRead = 1'b0; dataAddr = '0; rst_n = 1'b1;
    send_frame(8'h3C, 1);
    rd_chk("rst_mid_status2", STAT, 32'h0000_0009);
    rd_chk("rst_mid_data", BASE, 32'h0000_003C);

    // Randomized traffic against the queue model
    m_q.delete(); m_ovf = 0; m_perr = 0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          logic [7:0] db;
          bit g;
          db = 8'($urandom);
          g = ($urandom_range(0, 3) != 0);
          send_frame(db, g);
          m_frame(db, g);
        end
        2: begin
          m_read(BASE, e);
          rd(BASE, d);
          chk($sformatf("rnd%0d_data", i), d, e);
        end
        default: begin
          a = ($urandom_range(0, 1) != 0) ? STAT : BASE + 32'(4 * $urandom_range(2, 5));
          m_read(a, e);
          rd(a, d);
          chk($sformatf("rnd%0d_reg", i), d, e);
        end
      endcase
      chk($sformatf("rnd%0d_irq", i), 32'(kbd_irq), 32'(m_q.size() != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
